// File: rtl/sb_pkg.sv
// Shared types for the store buffer: entry state, entry record, LSU access
// size and the byte-enable helper used by both the fill path and forwarding.
package sb_pkg;

  localparam int XLEN     = 32;
  localparam int PLEN     = 32;
  localparam int SB_DEPTH = 16;
  localparam int SB_IDW   = $clog2(SB_DEPTH);
  localparam int STRBW    = XLEN / 8;

  typedef enum logic [1:0] {
    LSU_SB,
    LSU_SH,
    LSU_SW
  } lsu_op_e;

  typedef enum logic [1:0] {
    SB_FREE,
    SB_ALLOC,
    SB_READY,
    SB_COMMITTED
  } sb_state_e;

  // addr is kept word-aligned; data and strb are already in their byte lanes
  typedef struct packed {
    sb_state_e        state;
    logic [PLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
    logic [STRBW-1:0] strb;
  } sb_entry_t;

  function automatic logic [STRBW-1:0] lsu_op_to_strb(lsu_op_e op, logic [1:0] addrLo);
    logic [STRBW-1:0] strb;
    case (op)
      LSU_SB:  strb = STRBW'(4'b0001) << addrLo;
      LSU_SH:  strb = STRBW'(4'b0011) << addrLo;
      default: strb = '1;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Age-ordered store-to-load forwarding search over the live window
// head..head+count-1; later (younger) matches override older ones.
module sb_fwd_match
  import sb_pkg::*;
(
  input  sb_entry_t         entries_i [SB_DEPTH],
  input  logic [SB_IDW-1:0] head_i,
  input  logic [SB_IDW:0]   count_i,
  input  logic [PLEN-1:0]   load_addr_i,
  input  lsu_op_e           load_op_i,
  output logic              hit_o,
  output logic              block_o,
  output logic [XLEN-1:0]   data_o
);

  logic [STRBW-1:0]  loadStrb;
  logic [PLEN-1:0]   loadWord;
  logic              anyAlloc;
  logic              found;
  logic              foundFull;
  logic [XLEN-1:0]   foundData;
  logic [SB_IDW-1:0] idx;

  always_comb begin
    loadStrb  = lsu_op_to_strb(load_op_i, load_addr_i[1:0]);
    loadWord  = {load_addr_i[PLEN-1:2], 2'b00};
    anyAlloc  = 1'b0;
    found     = 1'b0;
    foundFull = 1'b0;
    foundData = '0;
    idx       = head_i;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = head_i + SB_IDW'(k);
      if ((SB_IDW+1)'(k) < count_i) begin
        if (entries_i[idx].state == SB_ALLOC) begin
          anyAlloc = 1'b1;
        end else if ((entries_i[idx].state == SB_READY ||
                      entries_i[idx].state == SB_COMMITTED) &&
                     entries_i[idx].addr == loadWord &&
                     (entries_i[idx].strb & loadStrb) != '0) begin
          found     = 1'b1;
          foundFull = ((entries_i[idx].strb & loadStrb) == loadStrb);
          foundData = entries_i[idx].data;
        end
      end
    end
  end

  // An unresolved address anywhere, or a partial cover, forces the load to wait
  assign block_o = anyAlloc | (found & ~foundFull);
  assign hit_o   = found & foundFull & ~block_o;
  assign data_o  = hit_o ? foundData : '0;

endmodule

// File: rtl/store_buffer.sv
// Circular store queue: allocate at dispatch, fill from LSU, commit from ROB,
// drain in order to the DCache store port, and forward to younger loads.
module store_buffer
  import sb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  output logic [SB_IDW-1:0] alloc_sb_id_o,
  input  logic              sb_ex_valid_i,
  input  logic [SB_IDW-1:0] sb_ex_sb_id_i,
  input  logic [PLEN-1:0]   sb_ex_addr_i,
  input  logic [XLEN-1:0]   sb_ex_data_i,
  input  lsu_op_e           sb_ex_op_i,
  input  logic              commit_valid_i,
  input  logic [SB_IDW-1:0] commit_sb_id_i,
  input  logic [PLEN-1:0]   sb_load_addr_i,
  input  lsu_op_e           sb_load_op_i,
  output logic              sb_load_hit_o,
  output logic              sb_load_block_o,
  output logic [XLEN-1:0]   sb_load_data_o,
  output logic              st_req_valid_o,
  input  logic              st_req_ready_i,
  output logic [PLEN-1:0]   st_req_addr_o,
  output logic [XLEN-1:0]   st_req_data_o,
  output logic [STRBW-1:0]  st_req_strb_o,
  output logic              empty_o
);

  localparam logic [SB_IDW:0] PTR_ONE   = (SB_IDW+1)'(1);
  localparam logic [SB_IDW:0] DEPTH_PTR = (SB_IDW+1)'(SB_DEPTH);

  sb_entry_t         entries_q [SB_DEPTH];
  sb_entry_t         entries_d [SB_DEPTH];
  logic [SB_IDW:0]   head_q, head_d;
  logic [SB_IDW:0]   cmt_q, cmt_d;
  logic [SB_IDW:0]   tail_q, tail_d;
  logic [SB_IDW:0]   count;
  logic [SB_IDW-1:0] headIdx, cmtIdx, tailIdx;
  logic              allocFire, exFire, commitFire, drainFire;

  assign headIdx = head_q[SB_IDW-1:0];
  assign cmtIdx  = cmt_q[SB_IDW-1:0];
  assign tailIdx = tail_q[SB_IDW-1:0];

  // Wrap bit in the MSB makes full (count==DEPTH) and empty (count==0) distinct
  assign count         = tail_q - head_q;
  assign alloc_ready_o = (count < DEPTH_PTR);
  assign alloc_sb_id_o = tailIdx;
  assign empty_o       = (count == '0);

  assign st_req_valid_o = (entries_q[headIdx].state == SB_COMMITTED);
  assign st_req_addr_o  = st_req_valid_o ? entries_q[headIdx].addr : '0;
  assign st_req_data_o  = st_req_valid_o ? entries_q[headIdx].data : '0;
  assign st_req_strb_o  = st_req_valid_o ? entries_q[headIdx].strb : '0;

  assign drainFire  = st_req_valid_o & st_req_ready_i;
  assign allocFire  = alloc_valid_i & alloc_ready_o & ~flush_i;
  assign exFire     = sb_ex_valid_i & (entries_q[sb_ex_sb_id_i].state == SB_ALLOC);
  assign commitFire = commit_valid_i & (entries_q[cmtIdx].state == SB_READY);

  // Updates applied in order: fill, commit, drain, flush, alloc
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    cmt_d     = cmt_q;
    tail_d    = tail_q;

    if (exFire) begin
      entries_d[sb_ex_sb_id_i].state = SB_READY;
      entries_d[sb_ex_sb_id_i].addr  = {sb_ex_addr_i[PLEN-1:2], 2'b00};
      entries_d[sb_ex_sb_id_i].data  = sb_ex_data_i << (8 * sb_ex_addr_i[1:0]);
      entries_d[sb_ex_sb_id_i].strb  = lsu_op_to_strb(sb_ex_op_i, sb_ex_addr_i[1:0]);
    end

    if (commitFire) begin
      entries_d[cmtIdx].state = SB_COMMITTED;
      cmt_d = cmt_q + PTR_ONE;
    end

    if (drainFire) begin
      entries_d[headIdx].state = SB_FREE;
      head_d = head_q + PTR_ONE;
    end

    if (flush_i) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (entries_d[i].state == SB_ALLOC || entries_d[i].state == SB_READY) begin
          entries_d[i].state = SB_FREE;
        end
      end
      tail_d = cmt_d;
    end

    if (allocFire) begin
      entries_d[tailIdx].state = SB_ALLOC;
      tail_d = tail_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
      for (int i = 0; i < SB_DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  sb_fwd_match u_fwd (
    .entries_i   (entries_q),
    .head_i      (headIdx),
    .count_i     (count),
    .load_addr_i (sb_load_addr_i),
    .load_op_i   (sb_load_op_i),
    .hit_o       (sb_load_hit_o),
    .block_o     (sb_load_block_o),
    .data_o      (sb_load_data_o)
  );

  // Protocol checks on the LSU fill and ROB commit interfaces
  exNotFree: assert property (@(posedge clk_i) disable iff (rst_i)
    sb_ex_valid_i |-> entries_q[sb_ex_sb_id_i].state != SB_FREE);
  commitInOrder: assert property (@(posedge clk_i) disable iff (rst_i)
    commit_valid_i |-> (commit_sb_id_i == cmtIdx && entries_q[cmtIdx].state == SB_READY));

endmodule
